alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_pkg.sv | 15 +
 rtl/arb2_grant.sv | 10 +
 rtl/alu_arbiter.sv | 93 +++++++++
 tb/tb_alu_arbiter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU op codes, arbiter FSM states and default operand width.
package alu_pkg;
  localparam int XLEN_DEFAULT = 32;
  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SLL  = 4'b0001;
  localparam logic [3:0] OP_SLT  = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SRA  = 4'b0110;
  localparam logic [3:0] OP_OR   = 4'b0111;
  localparam logic [3:0] OP_AND  = 4'b1000;
  localparam logic [3:0] OP_SUB  = 4'b1001;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
endpackage

// File: rtl/arb2_grant.sv
// arb2_grant: two-way one-hot grant; on contention the requester not named by ptr (last granted) wins.
module arb2_grant (
  input  logic       valid0,
  input  logic       valid1,
  input  logic       ptr,
  output logic [1:0] gnt
);
  assign gnt[0] = valid0 & (~valid1 | ptr);
  assign gnt[1] = valid1 & (~valid0 | ~ptr);
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters (IDLE -> EXEC -> RESP).
// Define ALU_ARB_ROUND_ROBIN_EN for round-robin arbitration; default gives requester 0 fixed priority.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  input  logic            req1_valid,
  output logic            req0_ready,
  output logic            req1_ready,
  input  logic [3:0]      req0_op,
  input  logic [3:0]      req1_op,
  input  logic [XLEN-1:0] req0_a,
  input  logic [XLEN-1:0] req0_b,
  input  logic [XLEN-1:0] req1_a,
  input  logic [XLEN-1:0] req1_b,
  output logic            resp0_valid,
  output logic            resp1_valid,
  input  logic            resp0_ready,
  input  logic            resp1_ready,
  output logic [XLEN-1:0] resp_data,
  output logic [3:0]      alu_op,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  input  logic [XLEN-1:0] alu_result,
  output logic            busy
);
  state_t          state;
  logic            gnt_id;
  logic [3:0]      op_q;
  logic [XLEN-1:0] a_q;
  logic [XLEN-1:0] b_q;
  logic            ptr;
  logic [1:0]      gnt;
  logic            hs0;
  logic            hs1;

  arb2_grant u_grant (
    .valid0(req0_valid),
    .valid1(req1_valid),
    .ptr   (ptr),
    .gnt   (gnt)
  );

  // rst gating keeps ready low while reset is held, not just after it lands
  assign req0_ready  = ~rst & (state == IDLE) & gnt[0];
  assign req1_ready  = ~rst & (state == IDLE) & gnt[1];
  assign hs0         = req0_valid & req0_ready;
  assign hs1         = req1_valid & req1_ready;
  assign resp0_valid = (state == RESP) & ~gnt_id;
  assign resp1_valid = (state == RESP) & gnt_id;
  assign busy        = state != IDLE;
  assign alu_op      = (state == EXEC) ? op_q : 4'd0;
  assign alu_a       = (state == EXEC) ? a_q : '0;
  assign alu_b       = (state == EXEC) ? b_q : '0;

`ifdef ALU_ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) ptr <= 1'b0;
    else if (hs0 | hs1) ptr <= hs1;
`else
  assign ptr = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state     <= IDLE;
      gnt_id    <= 1'b0;
      op_q      <= 4'd0;
      a_q       <= '0;
      b_q       <= '0;
      resp_data <= '0;
    end else begin
      case (state)
        IDLE: if (hs0 | hs1) begin
          state  <= EXEC;
          gnt_id <= hs1;
          op_q   <= hs1 ? req1_op : req0_op;
          a_q    <= hs1 ? req1_a : req0_a;
          b_q    <= hs1 ? req1_b : req0_b;
        end
        EXEC: begin
          resp_data <= alu_result;
          state     <= RESP;
        end
        RESP: if (gnt_id ? resp1_ready : resp0_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: randomized self-checking bench with an ALU model and a transaction-level arbiter model.
module tb_alu_arbiter;
  import alu_pkg::*;
  localparam int XLEN = 32;
`ifdef ALU_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic req0_valid, req1_valid, req0_ready, req1_ready;
  logic [3:0] req0_op, req1_op, alu_op;
  logic [XLEN-1:0] req0_a, req0_b, req1_a, req1_b, resp_data, alu_a, alu_b, alu_result;
  logic resp0_valid, resp1_valid, resp0_ready, resp1_ready, busy;

  int checks = 0;
  int failures = 0;
  bit last = 1'b0;

  alu_arbiter #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_op(req0_op), .req1_op(req1_op),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .resp0_valid(resp0_valid), .resp1_valid(resp1_valid),
    .resp0_ready(resp0_ready), .resp1_ready(resp1_ready),
    .resp_data(resp_data), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [XLEN-1:0] ref_alu(input logic [3:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SLL:  return a << b[4:0];
      OP_SLT:  return ($signed(a) < $signed(b)) ? 1 : 0;
      OP_SLTU: return (a < b) ? 1 : 0;
      OP_XOR:  return a ^ b;
      OP_SRL:  return a >> b[4:0];
      OP_SRA:  return $unsigned($signed(a) >>> b[4:0]);
      OP_OR:   return a | b;
      OP_AND:  return a & b;
      OP_SUB:  return a - b;
      default: return a ^ b ^ 32'h5a5a_a5a5;
    endcase
  endfunction

  assign alu_result = ref_alu(alu_op, alu_a, alu_b);

  task automatic idle_inputs();
    req0_valid = 0; req1_valid = 0; resp0_ready = 0; resp1_ready = 0;
    req0_op = 0; req1_op = 0; req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    req0_valid = 1;
    #3;
    checks++;
    if ({req0_ready, req1_ready, resp0_valid, resp1_valid, busy} !== 5'b0 || resp_data !== 0 || alu_op !== 0 || alu_a !== 0 || alu_b !== 0) begin
      failures++;
      $display("FAIL reset_outputs: rdy=%b%b rv=%b%b busy=%b data=%h op=%h a=%h b=%h required all 0",
               req0_ready, req1_ready, resp0_valid, resp1_valid, busy, resp_data, alu_op, alu_a, alu_b);
    end
    req0_valid = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    last = 1'b0;
  endtask

  // One full transaction: arbitration, EXEC forwarding, RESP with 'hold' cycles of backpressure.
  task automatic run_one(input bit v0, input bit v1,
                         input logic [3:0] o0, input logic [XLEN-1:0] a0, input logic [XLEN-1:0] b0,
                         input logic [3:0] o1, input logic [XLEN-1:0] a1, input logic [XLEN-1:0] b1,
                         input int hold);
    bit w;
    logic [3:0] eo;
    logic [XLEN-1:0] ea, eb, er;
    w  = (v0 && v1) ? (RR ? ~last : 1'b0) : v1;
    eo = w ? o1 : o0;
    ea = w ? a1 : a0;
    eb = w ? b1 : b0;
    er = ref_alu(eo, ea, eb);
    req0_valid = v0; req0_op = o0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_op = o1; req1_a = a1; req1_b = b1;
    @(negedge clk);
    checks++;
    if ({req1_ready, req0_ready} !== (w ? 2'b10 : 2'b01) || busy !== 1'b0) begin
      failures++;
      $display("FAIL grant: ready=%b busy=%b required ready=%b busy=0", {req1_ready, req0_ready}, busy, w ? 2'b10 : 2'b01);
    end
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
    last = w;
    @(negedge clk);
    checks++;
    if (alu_op !== eo || alu_a !== ea || alu_b !== eb || busy !== 1'b1 || {req1_ready, req0_ready, resp1_valid, resp0_valid} !== 4'b0) begin
      failures++;
      $display("FAIL exec: op=%h a=%h b=%h busy=%b rdy=%b%b rv=%b%b required op=%h a=%h b=%h busy=1 others 0",
               alu_op, alu_a, alu_b, busy, req1_ready, req0_ready, resp1_valid, resp0_valid, eo, ea, eb);
    end
    @(posedge clk); #1;
    if (w) resp0_ready = 1; else resp1_ready = 1;
    for (int i = 0; i <= hold; i++) begin
      if (i == hold) begin
        if (w) resp1_ready = 1; else resp0_ready = 1;
      end
      @(negedge clk);
      checks++;
      if ({resp1_valid, resp0_valid} !== (w ? 2'b10 : 2'b01) || resp_data !== er || busy !== 1'b1 ||
          {req1_ready, req0_ready} !== 2'b0 || alu_op !== 0 || alu_a !== 0 || alu_b !== 0) begin
        failures++;
        $display("FAIL resp[%0d]: rv=%b data=%h busy=%b rdy=%b op=%h required rv=%b data=%h busy=1 rdy=00 op=0",
                 i, {resp1_valid, resp0_valid}, resp_data, busy, {req1_ready, req0_ready}, alu_op, w ? 2'b10 : 2'b01, er);
      end
      @(posedge clk); #1;
    end
    resp0_ready = 0; resp1_ready = 0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || {resp1_valid, resp0_valid} !== 2'b0) begin
      failures++;
      $display("FAIL back_to_idle: busy=%b rv=%b required 0/00", busy, {resp1_valid, resp0_valid});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    run_one(1, 0, OP_ADD, 5, 7, 0, 0, 0, 0);
  endtask

  task automatic test_simultaneous();
    run_one(1, 1, OP_SUB, 10, 3, OP_AND, 32'hF0, 32'h3C, 0);
    run_one(~last, last, OP_SUB, 10, 3, OP_AND, 32'hF0, 32'h3C, 0);
  endtask

  task automatic test_backpressure();
    run_one(0, 1, 0, 0, 0, OP_XOR, 32'h1234_5678, 32'h0F0F_0F0F, 5);
  endtask

  task automatic test_undefined_op();
    run_one(0, 1, 0, 0, 0, 4'b1111, 1, 2, 1);
  endtask

  task automatic test_withdrawn();
    req1_valid = 1; req1_op = OP_OR; req1_a = 3; req1_b = 4;
    @(negedge clk);
    req1_valid = 0;
    #1;
    checks++;
    if (req1_ready !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL withdrawn_ready: ready=%b busy=%b required 0/0", req1_ready, busy);
    end
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || alu_op !== 0) begin
        failures++;
        $display("FAIL withdrawn_idle[%0d]: busy=%b op=%h required 0/0", i, busy, alu_op);
      end
      @(posedge clk); #1;
    end
    // an unchanged pointer shows up in the next contended grant
    run_one(1, 1, OP_SLT, 32'hFFFF_FFFF, 1, OP_SLTU, 32'hFFFF_FFFF, 1, 0);
  endtask

  task automatic test_reset_mid_exec();
    bit seen = 0;
    req1_valid = 1; req1_op = OP_ADD; req1_a = 100; req1_b = 23;
    @(posedge clk); #1;
    req1_valid = 0;
    #2;
    rst = 1;
    #1;
    checks++;
    if ({req0_ready, req1_ready, resp0_valid, resp1_valid, busy} !== 5'b0 || resp_data !== 0 || alu_op !== 0 || alu_a !== 0 || alu_b !== 0) begin
      failures++;
      $display("FAIL reset_mid_exec: rdy=%b%b rv=%b%b busy=%b data=%h op=%h a=%h b=%h required all 0",
               req0_ready, req1_ready, resp0_valid, resp1_valid, busy, resp_data, alu_op, alu_a, alu_b);
    end
    @(posedge clk); #1;
    rst = 0;
    last = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (resp0_valid || resp1_valid || busy) seen = 1;
      @(posedge clk); #1;
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL reset_discard: stale response or busy after reset, required none");
    end
    run_one(1, 0, OP_SLL, 1, 4, 0, 0, 0, 0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 24; n++) begin
      bit v0, v1;
      v0 = 1'($urandom_range(0, 1));
      v1 = v0 ? 1'($urandom_range(0, 1)) : 1'b1;
      run_one(v0, v1, 4'($urandom_range(0, 15)), $urandom, $urandom,
              4'($urandom_range(0, 15)), $urandom, $urandom, $urandom_range(0, 3));
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_backpressure();
    test_undefined_op();
    test_withdrawn();
    test_reset_mid_exec();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
